// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Pure declarations, no logic or latency.
// No flow control lives here.
package fetch_pkg;

  // Fetch sequencer states: idle, request outstanding, or draining a flushed request.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  // One buffered fetch result: the address it came from and the instruction word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // addi x0,x0,0 - a harmless bubble filler.
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch queue holding fetch_entry_t results for decode.
// Head visible combinationally; push lands at the next edge.
// Caller must not push when full; clear wins over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  fetch_entry_t data_i,
  input  logic         pop_i,
  input  logic         clear_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [CW-1:0] count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + 1'b1;
      if (pop_i)  rd_d = rd_q + 1'b1;
      if (push_i && !pop_i)      cnt_d = cnt_q + 1'b1;
      else if (pop_i && !push_i) cnt_d = cnt_q - 1'b1;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents need no reset because emptiness masks them.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_q] <= data_i;
  end

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  // The sequencer only issues with a free slot, so a push can never meet a full queue.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o && !clear_i));

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: issues one IMEM request at a time and queues results for decode.
// IF_VALID rises the cycle after IMEM_ACK; at most one request per two cycles.
// Stops issuing while the queue is full; FLUSH discards queued and in-flight work.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] PC_CUR,
  output logic        PC_WRITE,
  input  logic        FLUSH,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_RDATA,
  output logic        IF_VALID,
  output logic [31:0] IF_INSTR,
  output logic [31:0] IF_PC,
  input  logic        ID_READY
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          issue, push, pop;
  logic          q_full, q_empty;
  logic [CW-1:0] q_count;
  fetch_entry_t  q_head, q_in;

  // Sequencer state and the PC of the outstanding request.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Next-state and issue/push decisions; an ACK outside S_WAIT carries nothing we want.
  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    issue    = 1'b0;
    push     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!FLUSH && !q_full) begin
          issue    = 1'b1;
          req_pc_d = PC_CUR;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (IMEM_ACK) begin
          push    = !FLUSH;
          state_d = S_IDLE;
        end else if (FLUSH) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (IMEM_ACK) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pop          = IF_VALID && ID_READY && !FLUSH;
  assign q_in.pc      = req_pc_q;
  assign q_in.instr   = IMEM_RDATA;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push),
    .data_i  (q_in),
    .pop_i   (pop),
    .clear_i (FLUSH),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count),
    .head_o  (q_head)
  );

  // Request strobe and PC enable are squashed during reset so the PC never moves then.
  assign IMEM_REQ  = issue && !RST;
  assign PC_WRITE  = (issue || FLUSH) && !RST;
  assign IMEM_ADDR = PC_CUR;

  // Head is masked to zero when empty so stale storage never reaches decode.
  assign IF_VALID = (q_count != '0);
  assign IF_INSTR = q_empty ? '0 : q_head.instr;
  assign IF_PC    = q_empty ? '0 : q_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic vs a queue model.
// Inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// IMEM response delay and decode readiness are randomized in the random phase.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 2;

  logic        CLK, RST, PC_WRITE, FLUSH, IMEM_REQ, IMEM_ACK, IF_VALID, ID_READY;
  logic [31:0] PC_CUR, IMEM_ADDR, IMEM_RDATA, IF_INSTR, IF_PC;

  int n_chk = 0;
  int n_pass = 0;

  logic        s_req, s_pcw, s_vld;
  logic [31:0] s_addr, s_instr, s_pc;

  fetch_unit #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .PC_CUR(PC_CUR), .PC_WRITE(PC_WRITE), .FLUSH(FLUSH),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA),
    .IF_VALID(IF_VALID), .IF_INSTR(IF_INSTR), .IF_PC(IF_PC), .ID_READY(ID_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One cycle: apply inputs, sample at the falling edge, then emulate the PC block at the rising edge.
  task automatic run_cycle(input logic ack, input logic [31:0] rd, input logic fl,
                           input logic [31:0] tgt, input logic rdy);
    IMEM_ACK = ack; IMEM_RDATA = rd; FLUSH = fl; ID_READY = rdy;
    #4;
    s_req = IMEM_REQ; s_pcw = PC_WRITE; s_addr = IMEM_ADDR;
    s_vld = IF_VALID; s_instr = IF_INSTR; s_pc = IF_PC;
    @(posedge CLK); #1;
    if (s_pcw) PC_CUR = fl ? tgt : PC_CUR + 32'd4;
  endtask

  task automatic do_reset(input logic [31:0] pc0);
    RST = 1'b1; FLUSH = 1'b0; IMEM_ACK = 1'b0; IMEM_RDATA = NOP_INSTR; ID_READY = 1'b0; PC_CUR = pc0;
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; FLUSH = 1'b1; IMEM_ACK = 1'b0; IMEM_RDATA = NOP_INSTR; ID_READY = 1'b1; PC_CUR = 32'h40;
    @(posedge CLK); @(posedge CLK); #4;
    n_chk++; if (IF_VALID !== 1'b0) $display("FAIL rst_vld: got %b want 0", IF_VALID); else n_pass++;
    n_chk++; if (IF_INSTR !== 32'h0) $display("FAIL rst_instr: got %h want 0", IF_INSTR); else n_pass++;
    n_chk++; if (IF_PC !== 32'h0) $display("FAIL rst_pc: got %h want 0", IF_PC); else n_pass++;
    n_chk++; if (IMEM_REQ !== 1'b0) $display("FAIL rst_req: got %b want 0", IMEM_REQ); else n_pass++;
    n_chk++; if (PC_WRITE !== 1'b0) $display("FAIL rst_pcw: got %b want 0", PC_WRITE); else n_pass++;
  endtask

  task automatic test_first_fetch();
    do_reset(32'h0);
    run_cycle(1'b0, NOP_INSTR, 1'b0, 32'h0, 1'b0);
    n_chk++; if (s_req !== 1'b1) $display("FAIL ff_req: got %b want 1", s_req); else n_pass++;
    n_chk++; if (s_pcw !== 1'b1) $display("FAIL ff_pcw: got %b want 1", s_pcw); else n_pass++;
    n_chk++; if (s_addr !== 32'h0) $display("FAIL ff_addr: got %h want 0", s_addr); else n_pass++;
    run_cycle(1'b1, 32'h00500093, 1'b0, 32'h0, 1'b0);
    n_chk++; if (s_vld !== 1'b0) $display("FAIL ff_vld_early: got %b want 0", s_vld); else n_pass++;
    n_chk++; if (s_req !== 1'b0) $display("FAIL ff_req_wait: got %b want 0", s_req); else n_pass++;
    run_cycle(1'b0, NOP_INSTR, 1'b0, 32'h0, 1'b0);
    n_chk++; if (s_vld !== 1'b1) $display("FAIL ff_vld: got %b want 1", s_vld); else n_pass++;
    n_chk++; if (s_pc !== 32'h0) $display("FAIL ff_ifpc: got %h want 0", s_pc); else n_pass++;
    n_chk++; if (s_instr !== 32'h00500093) $display("FAIL ff_instr: got %h want 00500093", s_instr); else n_pass++;
  endtask

  task automatic test_fill_and_refill();
    do_reset(32'h0);
    run_cycle(1'b0, NOP_INSTR, 1'b0, 32'h0, 1'b0);
    run_cycle(1'b1, 32'hAAAA0001, 1'b0, 32'h0, 1'b0);
    run_cycle(1'b0, NOP_INSTR, 1'b0, 32'h0, 1'b0);
    n_chk++; if (s_addr !== 32'h4 || s_req !== 1'b1) $display("FAIL fill_req2: got req %b addr %h want 1/4", s_req, s_addr); else n_pass++;
    run_cycle(1'b1, 32'hBBBB0002, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      run_cycle(1'b0, NOP_INSTR, 1'b0, 32'h0, 1'b0);
      n_chk++; if (s_req !== 1'b0) $display("FAIL full_req: got %b want 0", s_req); else n_pass++;
      n_chk++; if (s_pcw !== 1'b0) $display("FAIL full_pcw: got %b want 0", s_pcw); else n_pass++;
    end
    n_chk++; if (PC_CUR !== 32'h8) $display("FAIL full_pc_stall: got %h want 8", PC_CUR); else n_pass++;
    run_cycle(1'b0, NOP_INSTR, 1'b0, 32'h0, 1'b1);
    n_chk++; if (s_vld !== 1'b1 || s_pc !== 32'h0) $display("FAIL pop_head: got vld %b pc %h want 1/0", s_vld, s_pc); else n_pass++;
    n_chk++; if (s_req !== 1'b0) $display("FAIL pop_req_same: got %b want 0", s_req); else n_pass++;
    run_cycle(1'b0, NOP_INSTR, 1'b0, 32'h0, 1'b0);
    n_chk++; if (s_pc !== 32'h4 || s_instr !== 32'hBBBB0002) $display("FAIL pop_next: got pc %h instr %h want 4/bbbb0002", s_pc, s_instr); else n_pass++;
    n_chk++; if (s_req !== 1'b1 || s_addr !== 32'h8) $display("FAIL refill_req: got req %b addr %h want 1/8", s_req, s_addr); else n_pass++;
  endtask

  task automatic test_flush_wait();
    do_reset(32'hC);
    run_cycle(1'b0, NOP_INSTR, 1'b0, 32'h0, 1'b0);
    run_cycle(1'b1, 32'h11110000, 1'b0, 32'h0, 1'b0);
    run_cycle(1'b0, NOP_INSTR, 1'b0, 32'h0, 1'b0);
    n_chk++; if (s_req !== 1'b1 || s_addr !== 32'h10) $display("FAIL fw_req: got req %b addr %h want 1/10", s_req, s_addr); else n_pass++;
    run_cycle(1'b0, NOP_INSTR, 1'b1, 32'h100, 1'b0);
    n_chk++; if (s_pcw !== 1'b1) $display("FAIL fw_pcw: got %b want 1", s_pcw); else n_pass++;
    run_cycle(1'b0, NOP_INSTR, 1'b0, 32'h0, 1'b0);
    n_chk++; if (s_vld !== 1'b0) $display("FAIL fw_empty: got %b want 0", s_vld); else n_pass++;
    n_chk++; if (s_req !== 1'b0) $display("FAIL fw_drop_req: got %b want 0", s_req); else n_pass++;
    run_cycle(1'b0, NOP_INSTR, 1'b0, 32'h0, 1'b0);
    run_cycle(1'b1, 32'hBAD0BAD0, 1'b0, 32'h0, 1'b0);
    n_chk++; if (s_req !== 1'b0) $display("FAIL fw_late_req: got %b want 0", s_req); else n_pass++;
    run_cycle(1'b0, NOP_INSTR, 1'b0, 32'h0, 1'b0);
    n_chk++; if (s_vld !== 1'b0) $display("FAIL fw_late_vld: got %b want 0", s_vld); else n_pass++;
    n_chk++; if (s_req !== 1'b1 || s_addr !== 32'h100) $display("FAIL fw_redirect: got req %b addr %h want 1/100", s_req, s_addr); else n_pass++;
    run_cycle(1'b1, 32'h22220000, 1'b0, 32'h0, 1'b0);
    run_cycle(1'b0, NOP_INSTR, 1'b0, 32'h0, 1'b0);
    n_chk++; if (s_instr !== 32'h22220000 || s_pc !== 32'h100) $display("FAIL fw_after: got instr %h pc %h want 22220000/100", s_instr, s_pc); else n_pass++;
  endtask

  task automatic test_flush_with_ack();
    do_reset(32'h0);
    run_cycle(1'b0, NOP_INSTR, 1'b0, 32'h0, 1'b0);
    run_cycle(1'b1, 32'h33330000, 1'b1, 32'h40, 1'b0);
    run_cycle(1'b0, NOP_INSTR, 1'b0, 32'h0, 1'b0);
    n_chk++; if (s_vld !== 1'b0) $display("FAIL fa_vld: got %b want 0", s_vld); else n_pass++;
    n_chk++; if (s_req !== 1'b1 || s_addr !== 32'h40) $display("FAIL fa_idle: got req %b addr %h want 1/40", s_req, s_addr); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset(32'h0);
    run_cycle(1'b0, NOP_INSTR, 1'b0, 32'h0, 1'b0);
    run_cycle(1'b1, 32'h44440000, 1'b0, 32'h0, 1'b0);
    run_cycle(1'b0, NOP_INSTR, 1'b0, 32'h0, 1'b0);
    IMEM_ACK = 1'b0; FLUSH = 1'b0; ID_READY = 1'b0;
    #1;
    n_chk++; if (IF_VALID !== 1'b1) $display("FAIL rm_pre_vld: got %b want 1", IF_VALID); else n_pass++;
    RST = 1'b1;
    #1;
    n_chk++; if (IF_VALID !== 1'b0 || IF_INSTR !== 32'h0 || IF_PC !== 32'h0)
      $display("FAIL rm_async: got vld %b instr %h pc %h want 0/0/0", IF_VALID, IF_INSTR, IF_PC); else n_pass++;
    n_chk++; if (IMEM_REQ !== 1'b0 || PC_WRITE !== 1'b0) $display("FAIL rm_req: got req %b pcw %b want 0/0", IMEM_REQ, PC_WRITE); else n_pass++;
    @(posedge CLK); #1;
    RST = 1'b0; PC_CUR = 32'h20;
    run_cycle(1'b1, 32'hDEAD0000, 1'b0, 32'h0, 1'b0);
    n_chk++; if (s_req !== 1'b1 || s_addr !== 32'h20) $display("FAIL rm_issue: got req %b addr %h want 1/20", s_req, s_addr); else n_pass++;
    run_cycle(1'b0, NOP_INSTR, 1'b0, 32'h0, 1'b0);
    n_chk++; if (s_vld !== 1'b0) $display("FAIL rm_stale_ack: got %b want 0", s_vld); else n_pass++;
    run_cycle(1'b1, 32'h55550000, 1'b0, 32'h0, 1'b0);
    run_cycle(1'b0, NOP_INSTR, 1'b0, 32'h0, 1'b0);
    n_chk++; if (s_instr !== 32'h55550000 || s_pc !== 32'h20) $display("FAIL rm_resume: got instr %h pc %h want 55550000/20", s_instr, s_pc); else n_pass++;
  endtask

  task automatic test_random();
    fetch_entry_t mq[$];
    fetch_entry_t e, hd;
    logic m_out, m_drp, fl, rdy, ack, exp_vld, exp_issue;
    logic [31:0] mpc, mreq, rd, tgt;
    do_reset(32'h0);
    m_out = 1'b0; m_drp = 1'b0; mpc = 32'h0; mreq = 32'h0;
    for (int c = 0; c < 600; c++) begin
      fl  = ($urandom_range(0, 11) == 0);
      rdy = $urandom_range(0, 1) == 1;
      ack = (m_out || m_drp) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
      rd  = $urandom;
      tgt = $urandom & 32'h0000_0FFC;
      exp_vld   = (mq.size() != 0);
      exp_issue = !m_out && !m_drp && !fl && (mq.size() < DEPTH);
      hd = exp_vld ? mq[0] : '0;
      run_cycle(ack, rd, fl, tgt, rdy);
      n_chk++; if (s_vld !== exp_vld) $display("FAIL rnd_vld c%0d: got %b want %b", c, s_vld, exp_vld); else n_pass++;
      if (exp_vld) begin
        n_chk++; if (s_pc !== hd.pc || s_instr !== hd.instr)
          $display("FAIL rnd_head c%0d: got %h/%h want %h/%h", c, s_pc, s_instr, hd.pc, hd.instr); else n_pass++;
      end
      n_chk++; if (s_req !== exp_issue) $display("FAIL rnd_req c%0d: got %b want %b", c, s_req, exp_issue); else n_pass++;
      n_chk++; if (s_pcw !== (exp_issue || fl)) $display("FAIL rnd_pcw c%0d: got %b want %b", c, s_pcw, exp_issue || fl); else n_pass++;
      if (exp_issue) begin
        n_chk++; if (s_addr !== mpc) $display("FAIL rnd_addr c%0d: got %h want %h", c, s_addr, mpc); else n_pass++;
      end
      if (fl) mq.delete();
      else begin
        if (exp_vld && rdy) void'(mq.pop_front());
        if (m_out && ack) begin e.pc = mreq; e.instr = rd; mq.push_back(e); end
      end
      if (m_out) begin
        if (ack) m_out = 1'b0;
        else if (fl) begin m_out = 1'b0; m_drp = 1'b1; end
      end else if (m_drp) begin
        if (ack) m_drp = 1'b0;
      end else if (exp_issue) begin
        m_out = 1'b1; mreq = mpc;
      end
      mpc = fl ? tgt : (exp_issue ? mpc + 32'd4 : mpc);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_fill_and_refill();
    test_flush_wait();
    test_flush_with_ack();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end that consumes the program-counter value, issues requests to instruction memory and buffers the returned instructions for decode.
- Drives the PC write enable, so the PC advances only when a fetch is actually issued or a redirect is applied.
- Discards in-flight and buffered instructions on a pipeline redirect (flush).
- Sits between the PC block / instruction memory and the decode stage.

Parameters:
- DEPTH, 2, number of fetch-queue entries; power of two, at least 2.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset; asynchronous, active-high.
- PC_CUR  in  32  current PC register value.
- PC_WRITE  out  1  PC load enable, to the PC block.
- FLUSH  in  1  redirect this cycle; the PC source selects the non-sequential target.
- IMEM_REQ  out  1  fetch request strobe; accepted in the same cycle.
- IMEM_ADDR  out  32  fetch address.
- IMEM_ACK  in  1  response valid; arrives one or more cycles after the request.
- IMEM_RDATA  in  32  instruction word, valid when IMEM_ACK is high.
- IF_VALID  out  1  queue head is valid.
- IF_INSTR  out  32  instruction at the queue head.
- IF_PC  out  32  PC of the instruction at the queue head.
- ID_READY  in  1  decode accepts the head this cycle.

Behaviour:
- Reset:
  - state = S_IDLE; count, read pointer and write pointer = 0; req_pc = 0.
  - IF_VALID = 0, IF_INSTR = 0, IF_PC = 0.
  - IMEM_REQ and PC_WRITE are forced to 0 while RST is high.
  - Reset asserted mid-operation abandons the outstanding request. The memory's later ACK lands in S_IDLE and is ignored.
- One request outstanding at most. State machine:
  - S_IDLE:
    - issue = !FLUSH && count < DEPTH.
    - When issue is true: IMEM_REQ = 1, IMEM_ADDR = PC_CUR, req_pc <= PC_CUR, next state S_WAIT.
    - IMEM_ACK is ignored in S_IDLE.
  - S_WAIT:
    - IMEM_REQ = 0.
    - IMEM_ACK && !FLUSH: push {req_pc, IMEM_RDATA}, go to S_IDLE.
    - IMEM_ACK && FLUSH: drop the response, go to S_IDLE.
    - !IMEM_ACK && FLUSH: go to S_DROP.
  - S_DROP: IMEM_REQ = 0. On IMEM_ACK the response is discarded and the state returns to S_IDLE. FLUSH in S_DROP keeps S_DROP.
- PC_WRITE = issue || FLUSH. The PC advances exactly once per issued request and loads the redirect target on FLUSH.
- Throughput: at most one fetch per two cycles (request in cycle N, ACK at N+1 at earliest, next request at N+2).
- Latency: an ACK in cycle M makes IF_VALID = 1 in cycle M+1, with IF_PC = address of the request.
- Queue:
  - Circular buffer with log2(DEPTH)-bit pointers that wrap from DEPTH-1 to 0.
  - IF_VALID = (count != 0). IF_INSTR and IF_PC read the head entry.
  - pop = IF_VALID && ID_READY && !FLUSH.
  - Push and pop in the same cycle: count is unchanged. This is legal even at count = DEPTH, because no push can occur in that case (no request was issued).
  - Overflow is impossible by construction: issue requires count < DEPTH and count cannot rise while waiting. Verification must assert this.
- FLUSH priority: FLUSH beats pop and push. Count and both pointers become 0 at the next edge, and IF_VALID = 0 in the following cycle.
- No alignment checking; IMEM_ADDR passes PC_CUR through unchanged.

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_t enum {S_IDLE, S_WAIT, S_DROP}.
  - fetch_entry_t struct {pc[31:0], instr[31:0]}.
  - Constant NOP_INSTR = 32'h00000013 (the bench uses it as a bubble filler).
- One sub-module, fetch_fifo:
  - Parameterised by DEPTH, storing fetch_entry_t.
  - Ports: push, pop, clear, full, empty, count, head.
  - Same async active-high reset.

Test Plan:
- Reset release, PC_CUR = 0x0, ACK one cycle after the request with 0x00500093:
  - IMEM_REQ and PC_WRITE are high in cycle 1.
  - IF_VALID rises in cycle 3 with IF_PC = 0x0 and IF_INSTR = 0x00500093.
- ID_READY held 0, PC_CUR stepping 0x0, 0x4, 0x8:
  - Two entries fill.
  - IMEM_REQ stays 0 while count = 2, and PC_WRITE stays 0 (PC stalls at 0x8).
- Queue full, ID_READY = 1 for one cycle:
  - Head 0x0 pops and count drops to 1.
  - A request for 0x8 issues the following cycle.
- FLUSH in S_WAIT (request 0x10 outstanding), ACK arriving 3 cycles later:
  - The queue empties and PC_WRITE = 1 on the FLUSH cycle.
  - The late ACK data is never visible on IF_INSTR.
  - The next request uses the new PC_CUR (0x100).
- FLUSH and IMEM_ACK in the same cycle: the response is dropped, IF_VALID = 0 next cycle, and state returns to S_IDLE.
- RST asserted while in S_WAIT: all outputs reach their reset values immediately without waiting for a clock edge, and a subsequent ACK is ignored.
